// File: rtl/ts_pkg.sv
// rtl/ts_pkg.sv - shared TS constants and mux FSM state type
package ts_pkg;
  localparam logic [7:0] TS_SYNC_BYTE = 8'h47;
  localparam int         TS_PKT_LEN   = 188;
  localparam int         TS_NUM_CHAN  = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } ts_state_e;
endpackage

// File: rtl/rr_arbiter4.sv
// rtl/rr_arbiter4.sv - 4-way round-robin grant, search starts after last winner
module rr_arbiter4 (
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx
);
  logic [1:0] cand;

  // Walk from lowest to highest priority so the highest-priority hit is written last.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    cand    = '0;
    for (int i = 4; i >= 1; i--) begin
      cand = last + 2'(i);
      if (req[cand]) begin
        gnt     = 4'b0001 << cand;
        gnt_idx = cand;
      end
    end
  end
endmodule

// File: rtl/ts_packet_mux.sv
// rtl/ts_packet_mux.sv - 4:1 TS packet multiplexer with whole-packet round-robin
// Optional per-channel discard counters under TS_MUX_STATS_EN.
module ts_packet_mux
  import ts_pkg::*;
#(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    PKT_LEN    = TS_PKT_LEN,
  parameter logic [DATA_WIDTH-1:0] SYNC_BYTE  = DATA_WIDTH'(TS_SYNC_BYTE)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            valid,
  input  logic [DATA_WIDTH-1:0] byte_data1,
  input  logic [DATA_WIDTH-1:0] byte_data2,
  input  logic [DATA_WIDTH-1:0] byte_data3,
  input  logic [DATA_WIDTH-1:0] byte_data4,
  output logic [3:0]            ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_sop,
  output logic                  out_eop,
  output logic [1:0]            out_chan,
  input  logic                  out_ready
`ifdef TS_MUX_STATS_EN
  ,
  output logic [15:0]           drop_cnt0,
  output logic [15:0]           drop_cnt1,
  output logic [15:0]           drop_cnt2,
  output logic [15:0]           drop_cnt3
`endif
);
  localparam int            CW       = $clog2(PKT_LEN);
  localparam logic [CW-1:0] LAST_IDX = CW'(PKT_LEN - 1);

  logic [DATA_WIDTH-1:0] din [TS_NUM_CHAN];
  assign din[0] = byte_data1;
  assign din[1] = byte_data2;
  assign din[2] = byte_data3;
  assign din[3] = byte_data4;

  ts_state_e             state_q, state_d;
  logic [CW-1:0]         byte_cnt_q, byte_cnt_d;
  logic [1:0]            grant_q, grant_d;
  logic [1:0]            last_grant_q, last_grant_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_sop_q, out_sop_d;
  logic                  out_eop_q, out_eop_d;
  logic [1:0]            out_chan_q, out_chan_d;

  logic [3:0] is_sync, eligible, discard, ready_c, gnt;
  logic [1:0] gnt_idx;
  logic       advance;

  always_comb begin
    is_sync = '0;
    for (int n = 0; n < TS_NUM_CHAN; n++) is_sync[n] = (din[n] == SYNC_BYTE);
  end

  assign eligible = valid & is_sync;
  assign advance  = !out_valid_q || out_ready;

  rr_arbiter4 u_arb (
    .req     (eligible),
    .last    (last_grant_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    out_valid_d  = advance ? 1'b0 : out_valid_q;
    out_data_d   = out_data_q;
    out_sop_d    = advance ? 1'b0 : out_sop_q;
    out_eop_d    = advance ? 1'b0 : out_eop_q;
    out_chan_d   = out_chan_q;
    ready_c      = '0;
    discard      = '0;

    case (state_q)
      ST_IDLE: begin
        if (advance) begin
          // Non-sync bytes are drained so the channel can realign on its next sync.
          discard = valid & ~is_sync;
          ready_c = discard | gnt;
          if (|eligible) begin
            out_valid_d = 1'b1;
            out_data_d  = din[gnt_idx];
            out_sop_d   = 1'b1;
            out_eop_d   = (LAST_IDX == '0);
            out_chan_d  = gnt_idx;
            grant_d     = gnt_idx;
            byte_cnt_d  = CW'(1);
            state_d     = ST_XFER;
          end
        end
      end
      ST_XFER: begin
        if (advance) begin
          ready_c = 4'b0001 << grant_q;
          if (valid[grant_q]) begin
            out_valid_d = 1'b1;
            out_data_d  = din[grant_q];
            out_chan_d  = grant_q;
            out_eop_d   = (byte_cnt_q == LAST_IDX);
            if (byte_cnt_q == LAST_IDX) begin
              state_d      = ST_IDLE;
              byte_cnt_d   = '0;
              last_grant_d = grant_q;
            end else begin
              byte_cnt_d = byte_cnt_q + CW'(1);
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign ready = ready_c & {4{rst_n}};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      byte_cnt_q   <= '0;
      grant_q      <= '0;
      last_grant_q <= 2'd3;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_sop_q    <= 1'b0;
      out_eop_q    <= 1'b0;
      out_chan_q   <= '0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_sop_q    <= out_sop_d;
      out_eop_q    <= out_eop_d;
      out_chan_q   <= out_chan_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sop   = out_sop_q;
  assign out_eop   = out_eop_q;
  assign out_chan  = out_chan_q;

`ifdef TS_MUX_STATS_EN
  logic [15:0] drop_q [TS_NUM_CHAN];
  logic [15:0] drop_d [TS_NUM_CHAN];

  always_comb begin
    for (int n = 0; n < TS_NUM_CHAN; n++) begin
      drop_d[n] = drop_q[n];
      if (discard[n] && (drop_q[n] != 16'hFFFF)) drop_d[n] = drop_q[n] + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    for (int n = 0; n < TS_NUM_CHAN; n++) begin
      if (!rst_n) drop_q[n] <= '0;
      else        drop_q[n] <= drop_d[n];
    end
  end

  assign drop_cnt0 = drop_q[0];
  assign drop_cnt1 = drop_q[1];
  assign drop_cnt2 = drop_q[2];
  assign drop_cnt3 = drop_q[3];
`endif
endmodule

// File: tb/tb_ts_packet_mux.sv
// tb/tb_ts_packet_mux.sv - directed bench for ts_packet_mux
module tb_ts_packet_mux;
  localparam int PKT = 188;

  typedef struct packed {
    logic [7:0] data;
    logic       sop;
    logic       eop;
    logic [1:0] chan;
  } ent_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] valid;
  logic [7:0] bd [4];
  logic [3:0] ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_sop, out_eop;
  logic [1:0] out_chan;
  logic       out_ready;
`ifdef TS_MUX_STATS_EN
  logic [15:0] dc0, dc1, dc2, dc3;
`endif

  logic [7:0] chq [4][$];
  bit         hold [4];
  ent_t       mon_q [$];
  int         checks = 0;
  int         fails  = 0;

  ts_packet_mux dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid      (valid),
    .byte_data1 (bd[0]),
    .byte_data2 (bd[1]),
    .byte_data3 (bd[2]),
    .byte_data4 (bd[3]),
    .ready      (ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_sop    (out_sop),
    .out_eop    (out_eop),
    .out_chan   (out_chan),
    .out_ready  (out_ready)
`ifdef TS_MUX_STATS_EN
    ,
    .drop_cnt0  (dc0),
    .drop_cnt1  (dc1),
    .drop_cnt2  (dc2),
    .drop_cnt3  (dc3)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] exp_byte(int c, int i);
    if (i == 0) return 8'h47;
    return 8'(i + c * 50);
  endfunction

  function automatic int pkt_bad(int base, int c);
    int bad = 0;
    if (mon_q.size() < base + PKT) return PKT;
    for (int i = 0; i < PKT; i++) begin
      if (mon_q[base+i].data !== exp_byte(c, i) || mon_q[base+i].sop !== (i == 0) ||
          mon_q[base+i].eop !== (i == PKT - 1) || mon_q[base+i].chan !== 2'(c)) bad++;
    end
    return bad;
  endfunction

  task automatic push_pkt(int c);
    for (int i = 0; i < PKT; i++) chq[c].push_back(exp_byte(c, i));
  endtask

  task automatic drive();
    for (int n = 0; n < 4; n++) begin
      valid[n] = !hold[n] && (chq[n].size() > 0);
      bd[n]    = (chq[n].size() > 0) ? chq[n][0] : 8'h00;
    end
  endtask

  task automatic step();
    logic [3:0] acc;
    @(negedge clk);
    acc = valid & ready;
    if (out_valid && out_ready) mon_q.push_back({out_data, out_sop, out_eop, out_chan});
    @(posedge clk);
    #1;
    for (int n = 0; n < 4; n++) if (acc[n]) void'(chq[n].pop_front());
    drive();
  endtask

  task automatic run_until(int n, int budget);
    int k = 0;
    while (mon_q.size() < n && k < budget) begin
      step();
      k++;
    end
  endtask

  task automatic reset_dut();
    rst_n     = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      chq[n].delete();
      hold[n] = 1'b0;
    end
    drive();
    repeat (2) @(posedge clk);
    #1;
    mon_q.delete();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    out_ready = 1'b1;
    chq[1].push_back(8'h12);
    drive();
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({out_valid, out_sop, out_eop, out_chan, out_data} !== 13'h0) begin
      fails++;
      $display("FAIL reset_outputs: got %h expected 0", {out_valid, out_sop, out_eop, out_chan, out_data});
    end
    checks++;
    if (ready !== 4'b0000) begin
      fails++;
      $display("FAIL reset_ready: got %b expected 0000", ready);
    end
`ifdef TS_MUX_STATS_EN
    checks++;
    if ({dc0, dc1, dc2, dc3} !== 64'h0) begin
      fails++;
      $display("FAIL reset_drop_cnt: got %h expected 0", {dc0, dc1, dc2, dc3});
    end
`endif
    reset_dut();
  endtask

  task automatic test_two_chan();
    int k = 0;
    int first = -1;
    reset_dut();
    push_pkt(0);
    push_pkt(2);
    drive();
    while (mon_q.size() < 2 * PKT && k < 1500) begin
      step();
      if (first < 0 && mon_q.size() > 0) first = k;
      k++;
    end
    repeat (5) step();
    checks++;
    if (first !== 1) begin
      fails++;
      $display("FAIL two_chan_latency: got step %0d expected 1", first);
    end
    checks++;
    if (mon_q.size() !== 2 * PKT) begin
      fails++;
      $display("FAIL two_chan_count: got %0d expected %0d", mon_q.size(), 2 * PKT);
    end
    checks++;
    if (pkt_bad(0, 0) !== 0) begin
      fails++;
      $display("FAIL two_chan_pkt0: got %0d bad bytes expected 0", pkt_bad(0, 0));
    end
    checks++;
    if (pkt_bad(PKT, 2) !== 0) begin
      fails++;
      $display("FAIL two_chan_pkt2: got %0d bad bytes expected 0", pkt_bad(PKT, 2));
    end
  endtask

  task automatic test_all_chan();
    int ord [5] = '{0, 1, 2, 3, 0};
    reset_dut();
    push_pkt(0);
    push_pkt(0);
    push_pkt(1);
    push_pkt(2);
    push_pkt(3);
    drive();
    run_until(5 * PKT, 3000);
    checks++;
    if (mon_q.size() !== 5 * PKT) begin
      fails++;
      $display("FAIL all_chan_count: got %0d expected %0d", mon_q.size(), 5 * PKT);
    end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (pkt_bad(k * PKT, ord[k]) !== 0) begin
        fails++;
        $display("FAIL all_chan_order: packet %0d got %0d bad bytes expected 0 (chan %0d)",
                 k, pkt_bad(k * PKT, ord[k]), ord[k]);
      end
    end
  endtask

  task automatic test_resync();
    reset_dut();
    for (int i = 1; i <= 5; i++) chq[1].push_back(8'(i));
    push_pkt(1);
    drive();
    run_until(PKT, 500);
    checks++;
    if (mon_q.size() !== PKT) begin
      fails++;
      $display("FAIL resync_count: got %0d expected %0d", mon_q.size(), PKT);
    end
    checks++;
    if (pkt_bad(0, 1) !== 0) begin
      fails++;
      $display("FAIL resync_pkt: got %0d bad bytes expected 0", pkt_bad(0, 1));
    end
`ifdef TS_MUX_STATS_EN
    checks++;
    if (dc1 !== 16'd5 || dc0 !== 16'd0) begin
      fails++;
      $display("FAIL resync_drop_cnt: got dc1=%0d dc0=%0d expected 5 and 0", dc1, dc0);
    end
`endif
  endtask

  task automatic test_backpressure();
    int bad = 0;
    reset_dut();
    push_pkt(0);
    drive();
    run_until(100, 300);
    out_ready = 1'b0;
    repeat (10) begin
      step();
      if (out_valid !== 1'b1 || out_data !== exp_byte(0, 100) || ready[0] !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0 || mon_q.size() !== 100) begin
      fails++;
      $display("FAIL backpressure_hold: got %0d unstable cycles, %0d bytes expected 0 and 100", bad, mon_q.size());
    end
    out_ready = 1'b1;
    run_until(PKT, 400);
    checks++;
    if (pkt_bad(0, 0) !== 0) begin
      fails++;
      $display("FAIL backpressure_pkt: got %0d bad bytes expected 0", pkt_bad(0, 0));
    end
  endtask

  task automatic test_stall();
    int bad = 0;
    reset_dut();
    push_pkt(3);
    drive();
    run_until(50, 200);
    hold[3] = 1'b1;
    push_pkt(0);
    drive();
    repeat (20) begin
      step();
      if (ready[0] !== 1'b0 || mon_q.size() > 51) bad++;
    end
    checks++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL stall_no_grant: got %0d bad cycles expected 0", bad);
    end
    hold[3] = 1'b0;
    drive();
    run_until(2 * PKT, 800);
    checks++;
    if (pkt_bad(0, 3) !== 0) begin
      fails++;
      $display("FAIL stall_pkt3: got %0d bad bytes expected 0", pkt_bad(0, 3));
    end
    checks++;
    if (pkt_bad(PKT, 0) !== 0) begin
      fails++;
      $display("FAIL stall_pkt0: got %0d bad bytes expected 0", pkt_bad(PKT, 0));
    end
  endtask

  task automatic test_reset_mid();
    int eops = 0;
    reset_dut();
    push_pkt(1);
    drive();
    run_until(50, 200);
    foreach (mon_q[i]) if (mon_q[i].eop) eops++;
    checks++;
    if (eops !== 0 || mon_q.size() !== 50) begin
      fails++;
      $display("FAIL reset_mid_partial: got %0d eops, %0d bytes expected 0 and 50", eops, mon_q.size());
    end
    rst_n = 1'b0;
    step();
    checks++;
    if ({out_valid, out_sop, out_eop, out_chan, out_data} !== 13'h0 || ready !== 4'b0000) begin
      fails++;
      $display("FAIL reset_mid_outputs: got %h ready %b expected 0 and 0000",
               {out_valid, out_sop, out_eop, out_chan, out_data}, ready);
    end
    rst_n = 1'b1;
    mon_q.delete();
    push_pkt(0);
    push_pkt(1);
    drive();
    run_until(2 * PKT, 1500);
    checks++;
    if (pkt_bad(0, 0) !== 0) begin
      fails++;
      $display("FAIL reset_mid_next_grant: got %0d bad bytes expected 0 (chan 0)", pkt_bad(0, 0));
    end
    checks++;
    if (pkt_bad(PKT, 1) !== 0) begin
      fails++;
      $display("FAIL reset_mid_ch1_pkt: got %0d bad bytes expected 0", pkt_bad(PKT, 1));
    end
  endtask

  initial begin
    valid     = '0;
    out_ready = 1'b1;
    rst_n     = 1'b0;
    for (int n = 0; n < 4; n++) begin
      bd[n]   = 8'h00;
      hold[n] = 1'b0;
    end
    test_reset();
    test_two_chan();
    test_all_chan();
    test_resync();
    test_backpressure();
    test_stall();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
